// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a decoded instruction descriptor into a 32-bit
// word through a two-stage valid/ready pipeline, rejecting out-of-range immediates.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] count_ok,
  output logic [CNT_W-1:0] count_err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Handshake: a word moves across an interface on a rising edge where valid and
  // ready are both high; a stage is ready when empty or when its word leaves that edge.
  logic             s1_ready, s2_ready, s1_load;
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_fmt_q;
  logic [6:0]       s1_opcode_q;
  logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]       s1_funct3_q;
  logic [6:0]       s1_funct7_q;
  logic [31:0]      s1_imm_q;
  logic             s1_imm_ok_q;
  logic             imm_ok;
  logic [31:0]      packed_word;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] count_ok_q, count_ok_d;
  logic [CNT_W-1:0] count_err_q, count_err_d;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_load  = in_valid && s1_ready;
  assign in_ready = s1_ready;

  // Immediate must be representable by the sign-extended field of its format.
  always_comb begin
    imm_ok = 1'b0;
    case (in_fmt)
      FMT_R:        imm_ok = 1'b1;
      FMT_I, FMT_S: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      FMT_B:        imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      FMT_U:        imm_ok = !(|in_imm[11:0]);
      FMT_J:        imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
      default:      imm_ok = 1'b0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_ready) s1_valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 3'd0;
      s1_opcode_q <= 7'd0;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_funct3_q <= 3'd0;
      s1_funct7_q <= 7'd0;
      s1_imm_q    <= 32'd0;
      s1_imm_ok_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_fmt_q    <= in_fmt;
        s1_opcode_q <= in_opcode;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_funct3_q <= in_funct3;
        s1_funct7_q <= in_funct7;
        s1_imm_q    <= in_imm;
        s1_imm_ok_q <= imm_ok;
      end
    end
  end

  always_comb begin
    packed_word = 32'h0;
    case (s1_fmt_q)
      FMT_R: packed_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_I: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:0], s1_opcode_q};
      FMT_B: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      FMT_U: packed_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      FMT_J: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, s1_opcode_q};
      default: packed_word = 32'h0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = s1_imm_ok_q ? packed_word : 32'h0;
        out_err_d   = !s1_imm_ok_q;
      end
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    count_ok_d  = count_ok_q;
    count_err_d = count_err_q;
    if (out_valid_q && out_ready) begin
      if (!out_err_q && (count_ok_q != '1)) count_ok_d = count_ok_q + CNT_W'(1);
      if (out_err_q && (count_err_q != '1)) count_err_d = count_err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_err_q   <= 1'b0;
      count_ok_q  <= '0;
      count_err_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      count_ok_q  <= count_ok_d;
      count_err_q <= count_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign count_ok  = count_ok_q;
  assign count_err = count_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, backpressure/reset/saturation
// sequences, then random traffic checked against a behavioural encoding model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid, out_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [15:0] count_ok, count_err;
  logic        sat_in_ready, sat_out_valid, sat_out_err;
  logic [31:0] sat_out_instr;
  logic [1:0]  sat_count_ok, sat_count_err;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .count_ok(count_ok), .count_err(count_err)
  );

  // Narrow-counter copy fed the same traffic, used for saturation checks.
  instr_encoder #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(sat_out_instr),
    .out_err(sat_out_err), .count_ok(sat_count_ok), .count_err(sat_count_err)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          n_chk = 0, n_err = 0, n_emit = 0;
  int          model_ok = 0, model_err = 0;
  bit          last_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding rules stated as signed ranges and field arithmetic.
  function automatic logic [32:0] model_word(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int          s;
    logic [31:0] u, w, regs;
    bit          ok;
    s = int'($signed(imm));
    u = imm;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w = 32'h0;
    ok = 0;
    case (fmt)
      3'd0: begin
        ok = 1;
        w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7);
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((u & 32'h1F) << 7);
      end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
            regs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      end
      3'd4: begin
        ok = (u % 4096 == 0);
        w = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048575) && (u % 2 == 0);
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
            (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(op);
      end
      default: ok = 0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic [31:0] instr, input logic err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.instr = instr; v.err = err;
    return v;
  endfunction

  task automatic set_desc(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic rand_desc();
    in_fmt = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: in_imm = $urandom;
      1: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: in_imm = $urandom & 32'hFFFFF000;
      default: in_imm = 32'(int'($urandom_range(0, 4194303)) - 2097152);
    endcase
  endtask

  // One clock: observe handshakes at the falling edge, then pass the rising edge.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc)
      exp_q.push_back(model_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
                                 in_funct7, in_imm));
    if (out_valid && out_ready) begin
      n_emit++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {out_err, out_instr}, 64'h1_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        chk("word", {out_err, out_instr}, e);
        chk("sat_word", {sat_out_valid, sat_out_err, sat_out_instr}, {1'b1, e});
        if (e[32]) model_err++; else model_ok++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_count_ok"}, count_ok, model_ok);
    chk({tag, "_count_err"}, count_err, model_err);
    chk({tag, "_sat_ok"}, sat_count_ok, (model_ok > 3) ? 3 : model_ok);
    chk({tag, "_sat_err"}, sat_count_err, (model_err > 3) ? 3 : model_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vec_t v;
    logic [32:0] exp_a;

    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        32'h008000EF, 1'b0));
    vecs.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,        32'h402081B3, 1'b0));
    vecs.push_back(mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFFFFF8, 32'hFE312C23, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd6,        32'h00208363, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000FFFFE, 32'h7FFFF0EF, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h0, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7,        32'h0, 1'b1));
    vecs.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 32'h0, 1'b1));
    vecs.push_back(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h0, 1'b1));
    vecs.push_back(mk(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h0, 1'b1));
    vecs.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h0, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4096,     32'h0, 1'b1));
    vecs.push_back(mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFFF7FF, 32'h0, 1'b1));

    // Reset state
    in_valid = 0; out_ready = 0;
    set_desc(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", out_err, 0);
    chk_counts("rst");
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // First descriptor: in S1 after the accepting edge, on the output after the next
    set_desc(vecs[0]);
    in_valid = 1; out_ready = 1;
    cycle();
    in_valid = 0;
    chk("lat_s1_only", out_valid, 0);
    cycle();
    chk("lat_out_valid", out_valid, 1);
    chk("lat_word", {out_err, out_instr}, {1'b0, 32'h00500093});
    cycle();
    chk("first_count_ok", count_ok, 1);

    // Directed vector table, one descriptor in flight at a time
    foreach (vecs[i]) begin
      set_desc(vecs[i]);
      in_valid = 1;
      chk("tab_in_ready", in_ready, 1);
      cycle();
      in_valid = 0;
      cycle();
      chk($sformatf("tab%0d_valid", i), out_valid, 1);
      chk($sformatf("tab%0d_word", i), {out_err, out_instr}, {vecs[i].err, vecs[i].instr});
      cycle();
    end
    chk_counts("tab");

    // Backpressure: two buffered, third blocked, blocked input changes ignored
    out_ready = 0;
    set_desc(vecs[0]); in_valid = 1; cycle();
    set_desc(vecs[1]); cycle();
    set_desc(vecs[3]);
    exp_a = {vecs[0].err, vecs[0].instr};
    chk("bp_in_ready", in_ready, 0);
    chk("bp_sat_in_ready", sat_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      in_fmt = 3'($urandom_range(0, 7));
      in_imm = $urandom;
      cycle();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_word", {out_err, out_instr}, exp_a);
      chk("bp_blocked", in_ready, 0);
    end
    set_desc(vecs[3]);
    out_ready = 1;
    e0 = n_emit;
    cycle();
    chk("bp_third_accepted", last_acc, 1);
    in_valid = 0;
    cycle();
    cycle();
    chk("bp_burst_len", n_emit - e0, 3);
    chk("bp_drained", exp_q.size(), 0);

    // Reset mid-stream with both stages full
    out_ready = 0;
    set_desc(vecs[2]); in_valid = 1; cycle();
    set_desc(vecs[6]); cycle();
    in_valid = 0;
    chk("mid_full", {out_valid, in_ready}, 2'b10);
    #2;
    reset_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count_ok", count_ok, 0);
    chk("mid_rst_count_err", count_err, 0);
    chk("mid_rst_sat_ok", sat_count_ok, 0);
    exp_q.delete();
    model_ok = 0; model_err = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {out_valid, in_ready}, 2'b01);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Five good words back to back: throughput and narrow-counter saturation
    out_ready = 1;
    e0 = n_emit;
    for (int k = 0; k < 5; k++) begin
      set_desc(vecs[k]);
      in_valid = 1;
      chk("sat_in_ready", in_ready, 1);
      cycle();
    end
    in_valid = 0;
    chk("stream_valid", out_valid, 1);
    cycle();
    cycle();
    chk("stream_count", n_emit - e0, 5);
    chk("sat_count_ok_main", count_ok, 5);
    chk("sat_count_ok_narrow", sat_count_ok, 3);
    chk_counts("sat");

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_desc();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
    chk("rand_drained", exp_q.size(), 0);
    chk_counts("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
